// File: rtl/muldiv_controller_pkg.sv
// muldiv_controller_pkg
//   Shared encodings for the multiply/divide sequencer: the op codes EX
//   presents on `op`, the controller state encoding, and small op decoders.
package muldiv_controller_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // op[1] selects divide, op[0] selects the unsigned flavour.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_controller_iter.sv
// muldiv_controller_iter
//   One-step-per-enable iteration datapath shared by multiply and divide.
//   acc holds {upper, lower} halves:
//     multiply : upper = partial product, lower = remaining multiplier bits
//     divide   : upper = partial remainder, lower = dividend/quotient bits
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : seed acc = {0, seed} and latch operand m
//   step       : perform one shift-add (mul) or restoring-subtract (div) step
//   is_div     : selects divide step when 1 (sampled on load)
//   seed       : multiplier (mul) or dividend (div)
//   m          : multiplicand (mul) or divisor (div)
//   acc        : 2*W-bit working register
module muldiv_controller_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   seed,
  input  logic [W-1:0]   m,
  output logic [2*W-1:0] acc
);

  logic [W-1:0] m_q;
  logic         div_q;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right (keeping
  // the carry as the new top bit).
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m_q} : '0);

  // Divide step: shift {rem, dividend} left one; the shifted remainder needs
  // W+1 bits. One extra bit on the difference acts as the borrow flag.
  logic [W:0]   rem_sh;
  logic [W+1:0] diff;
  logic         borrow;
  assign rem_sh = acc[2*W-1:W-1];
  assign diff   = {1'b0, rem_sh} - {2'b00, m_q};
  assign borrow = diff[W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= {{W{1'b0}}, seed};
      m_q   <= m;
      div_q <= is_div;
    end else if (step) begin
      if (!div_q)
        acc <= {mul_sum, acc[W-1:1]};
      else if (!borrow)
        acc <= {diff[W-1:0], acc[W-2:0], 1'b1};
      else
        acc <= {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// muldiv_controller
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   IDLE -> BUSY (DATA_WIDTH iterations) -> FIX (sign correction, HI/LO
//   commit) -> DONE (one-cycle done pulse) -> IDLE. flush aborts anywhere.
// Handshake: a request is `start` held in EX; it is accepted in IDLE when
//   !flush. `stall` holds EX until the DONE cycle, in which `start` still
//   shows the same instruction and is ignored.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start, op, rs, rt : request, op code, operands
//   flush             : abort in-flight op, no commit, no done
//   wr_hi, wr_lo      : MTHI/MTLO enables (IDLE/DONE only), data on wr_data
//   stall, busy, done : pipeline hold, BUSY|FIX, result-commit pulse
//   hi, lo            : architectural HI/LO
module muldiv_controller
  import muldiv_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  input  logic                  flush,
  input  logic                  wr_hi,
  input  logic                  wr_lo,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;

  md_state_e            state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sign_a, sign_b, is_div, is_sgn, b_zero;
  logic                 accept, last_iter;
  logic [W-1:0]         rs_abs, rt_abs;
  logic [2*W-1:0]       acc;

  assign accept    = (state == ST_IDLE) && start && !flush;
  assign last_iter = (cnt == CNT_WIDTH'(W - 1));

  // Signed ops iterate on magnitudes; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  assign rs_abs = (op_is_signed(op) && rs[W-1]) ? -rs : rs;
  assign rt_abs = (op_is_signed(op) && rt[W-1]) ? -rt : rt;

  muldiv_controller_iter #(.W(W)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == ST_BUSY),
    .is_div (op_is_div(op)),
    .seed   (op_is_div(op) ? rs_abs : rt_abs),
    .m      (op_is_div(op) ? rt_abs : rs_abs),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = accept;
        if (accept) state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (last_iter) state_nx = ST_FIX;
      end
      ST_FIX: begin
        stall    = 1'b1;
        busy     = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = !flush;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  // Counter and operand attributes captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      sign_a <= rs[W-1];
      sign_b <= rt[W-1];
      is_div <= op_is_div(op);
      is_sgn <= op_is_signed(op);
      b_zero <= (rt == '0);
    end else if (state == ST_BUSY) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sign correction. A zero divisor leaves the dividend magnitude in the
  // remainder, so the remainder fix alone restores hi=rs; lo is forced.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, hi_res, lo_res;
  assign prod_fix = (is_sgn && (sign_a ^ sign_b)) ? -acc : acc;
  assign quot_fix = (is_sgn && (sign_a ^ sign_b)) ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = (is_sgn && sign_a) ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign hi_res   = is_div ? rem_fix : prod_fix[2*W-1:W];
  assign lo_res   = is_div ? (b_zero ? {W{1'b1}} : quot_fix) : prod_fix[W-1:0];

  logic wr_open;
  assign wr_open = (state == ST_IDLE) || (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX) begin
      if (!flush) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end else if (wr_open) begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// tb_muldiv_controller
//   Bench for muldiv_controller: directed cases plus random ops checked
//   against an arithmetic reference model through an expected queue.
module tb_muldiv_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0, rt = '0, wr_data = '0;
  logic        flush = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

  muldiv_controller #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    case (o)
      2'b00: return longint'($signed(a)) * longint'($signed(b));
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one op in the next IDLE cycle (cycle 0), checks stall over
  // cycles 0..33, done at cycle 34 and the committed HI/LO.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    logic        stall_ok;
    logic [63:0] e;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    #1 stall_ok = (stall === 1'b1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_stall"}, 64'(stall_ok), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc), 64'd34);
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] hold_hi, hold_lo;
  logic [63:0] e64;
  logic        saw_done;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    do_reset();
    #1;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_flags", {61'b0, stall, busy, done}, 64'h0);

    // Directed arithmetic cases.
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    // Back-to-back DIVU: second starts the cycle after the first's DONE.
    run_op("divu_b2b0", 2'b11, 32'd1000, 32'd7);
    run_op("divu_b2b1", 2'b11, 32'hDEAD_BEEF, 32'd13);

    // Start held through DONE must be ignored.
    exp_q.push_back(model(2'b00, 32'd5, 32'hFFFF_FFFD));
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs = 32'd5; rt = 32'hFFFF_FFFD;
    repeat (34) @(negedge clk);
    check("hold_done", 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    #1 check("hold_idle_busy", 64'(busy), 64'd0);
    e64 = exp_q.pop_front();
    check("hold_hilo", {hi, lo}, e64);

    // MTHI in IDLE.
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_idle", 64'(hi), 64'h1234);

    // Same-cycle MTLO with start: write lands, op starts.
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'd9; rt = 32'd4; wr_lo = 1'b1; wr_data = 32'h5555;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("mtlo_start_lo", 64'(lo), 64'h5555);
    check("mtlo_start_busy", 64'(busy), 64'd1);
    repeat (40) @(negedge clk);
    check("mtlo_start_hilo", {hi, lo}, {32'd1, 32'd2});

    // DIV with MTLO during BUSY (ignored) and flush at cycle 10.
    hold_hi = hi; hold_lo = lo;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs = 32'd100; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'hAAAA_AAAA;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_busy", 64'(lo), 64'(hold_lo));
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {62'b0, stall, busy}, 64'h0);
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_hilo", {hi, lo}, {hold_hi, hold_lo});

    // Flush in DONE: result committed, done suppressed.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs = 32'h0001_0000; rt = 32'h0003_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_done_pulse", 64'(done), 64'd0);
    check("flush_done_hilo", {hi, lo}, 64'h0000_0003_0000_0000);
    @(negedge clk);
    flush = 1'b0;

    // Reset at BUSY cycle 5.
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'd50; rt = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {61'b0, stall, busy, done}, 64'h0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random ops; small divisors and zeros mixed in for boundary coverage.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op("rand", ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
